// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned REGW = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Execute-stage operand bypass select; Memory stage wins over Writeback.
    function automatic fwd_sel_t fwd_select(
        input logic [REGW-1:0] src,
        input logic [REGW-1:0] dst_m,
        input logic            wr_m,
        input logic [REGW-1:0] dst_w,
        input logic            wr_w
    );
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (src != '0 && wr_m && src == dst_m) begin
            sel = FWD_M;
        end else if (src != '0 && wr_w && src == dst_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state handshake with timeout and sticky error flag.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic memaccM,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic memstall,
    output logic mem_error
);

    localparam int unsigned WCW = $clog2(TIMEOUT + 1);

    mem_state_t     state;
    mem_state_t     state_next;
    logic [WCW-1:0] wcnt;
    logic [WCW-1:0] wcnt_next;
    logic           err_next;
    logic           req_raw;
    logic           stall_raw;

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_next;
            wcnt      <= wcnt_next;
            mem_error <= err_next;
        end
    end

    // Next-state and handshake outputs; a timed-out access is dropped.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        err_next   = mem_error;
        req_raw    = 1'b0;
        stall_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (memaccM) begin
                    req_raw   = 1'b1;
                    stall_raw = ~dmem_ready;
                    if (!dmem_ready) begin
                        state_next = WAIT;
                        wcnt_next  = WCW'(1);
                    end
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (dmem_ready) begin
                    state_next = IDLE;
                end else if (wcnt == WCW'(TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall_raw = 1'b1;
                    wcnt_next = wcnt + WCW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dmem_req = req_raw & ~reset;
    assign memstall = stall_raw & ~reset;

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection, forwarding, stall/flush control and stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rsD,
    input  logic [4:0]      rtD,
    input  logic [4:0]      rsE,
    input  logic [4:0]      rtE,
    input  logic [4:0]      writeregE,
    input  logic [4:0]      writeregM,
    input  logic [4:0]      writeregW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memtoregE,
    input  logic            memtoregM,
    input  logic            memwriteM,
    input  logic            branchD,
    input  logic            bneD,
    input  logic            jumpD,
    input  logic            pcsrcD,
    input  logic            dmem_ready,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushD,
    output logic            flushE,
    output logic            flushW,
    output logic            forwardAD,
    output logic            forwardBD,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            dmem_req,
    output logic            mem_error,
    output logic [CNTW-1:0] stall_count
);

    logic lwstall;
    logic branchstall;
    logic memstall;
    logic memaccM;
    logic front_stall;

    assign memaccM = memtoregM | memwriteM;

    mem_wait_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .memaccM   (memaccM),
        .dmem_ready(dmem_ready),
        .dmem_req  (dmem_req),
        .memstall  (memstall),
        .mem_error (mem_error)
    );

    // Hazard detection, forwarding selects and stall/flush outputs.
    always_comb begin
        lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
        branchstall = (branchD | bneD) &
                      ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                       (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
        front_stall = lwstall | branchstall | memstall;

        stallF    = front_stall & ~reset;
        stallD    = front_stall & ~reset;
        stallE    = memstall;
        stallM    = memstall;
        flushE    = (lwstall | branchstall) & ~memstall & ~reset;
        flushD    = (pcsrcD | jumpD) & ~front_stall & ~reset;
        flushW    = memstall;

        forwardAD = (rsD != '0) & regwriteM & (rsD == writeregM) & ~reset;
        forwardBD = (rtD != '0) & regwriteM & (rtD == writeregM) & ~reset;
        forwardAE = reset ? FWD_NONE : fwd_select(rsE, writeregM, regwriteM, writeregW, regwriteW);
        forwardBE = reset ? FWD_NONE : fwd_select(rtE, writeregM, regwriteM, writeregW, regwriteW);
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stallF && stall_count != '1) begin
            stall_count <= stall_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memwriteM;
    logic        branchD, bneD, jumpD, pcsrcD, dmem_ready;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic        forwardAD, forwardBD, dmem_req, mem_error;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stall_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_sc = 0;

    hazard_unit #(.TIMEOUT(16), .CNTW(32)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .branchD(branchD), .bneD(bneD), .jumpD(jumpD), .pcsrcD(pcsrcD),
        .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .dmem_req(dmem_req), .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; memwriteM = 0;
        branchD = 0; bneD = 0; jumpD = 0; pcsrcD = 0; dmem_ready = 0;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        // Hazard present during reset must be masked.
        memtoregE = 1; rtE = 5'd8; rsD = 5'd8;
        #1;
        check("rst_stallF", 32'(stallF), 32'd0);
        check("rst_flushE", 32'(flushE), 32'd0);
        step();
        step();
        check("rst_count", stall_count, 32'd0);
        check("rst_err", 32'(mem_error), 32'd0);
        reset = 1'b0;
        clr();
        #1;

        // Forwarding priority M over W, and r0 never forwarded.
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 1; writeregW = 5'd5; regwriteW = 1;
        #1;
        check("fwdAE_m", 32'(forwardAE), 32'd2);
        check("fwdBE_none", 32'(forwardBE), 32'd0);
        regwriteM = 0;
        #1;
        check("fwdAE_w", 32'(forwardAE), 32'd1);
        rsE = 5'd0;
        #1;
        check("fwdAE_zero", 32'(forwardAE), 32'd0);
        rtE = 5'd9; writeregW = 5'd9;
        rsD = 5'd7; writeregM = 5'd7; regwriteM = 1;
        #1;
        check("fwdBE_w", 32'(forwardBE), 32'd1);
        check("fwdAD", 32'(forwardAD), 32'd1);
        check("fwdBD", 32'(forwardBD), 32'd0);
        step();
        clr();

        // Load-use stall.
        memtoregE = 1; rtE = 5'd8; rsD = 5'd8;
        #1;
        check("lw_stallF", 32'(stallF), 32'd1);
        check("lw_stallD", 32'(stallD), 32'd1);
        check("lw_flushE", 32'(flushE), 32'd1);
        check("lw_stallE", 32'(stallE), 32'd0);
        step();
        exp_sc = exp_sc + 1;
        memtoregE = 0;
        #1;
        check("lw_clr_stallF", 32'(stallF), 32'd0);
        check("lw_clr_flushE", 32'(flushE), 32'd0);
        check("lw_count", stall_count, exp_sc);
        clr();

        // Branch hazard; a taken branch that is stalled does not flush D.
        branchD = 1; rsD = 5'd3; regwriteE = 1; writeregE = 5'd3; pcsrcD = 1;
        #1;
        check("br_stallD", 32'(stallD), 32'd1);
        check("br_flushE", 32'(flushE), 32'd1);
        check("br_flushD_held", 32'(flushD), 32'd0);
        step();
        exp_sc = exp_sc + 1;
        clr();
        pcsrcD = 1;
        #1;
        check("br_flushD", 32'(flushD), 32'd1);
        check("br_nostall", 32'(stallD), 32'd0);
        clr();

        // Memory wait: three not-ready cycles then ready.
        memtoregM = 1;
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            if (i == 1) begin
                memtoregE = 1; rtE = 5'd8; rsD = 5'd8;
            end else begin
                memtoregE = 0; rtE = '0; rsD = '0;
            end
            #1;
            check("mw_req", 32'(dmem_req), 32'd1);
            check("mw_stallF", 32'(stallF), 32'(i < 3));
            check("mw_stallE", 32'(stallE), 32'(i < 3));
            check("mw_stallM", 32'(stallM), 32'(i < 3));
            check("mw_flushW", 32'(flushW), 32'(i < 3));
            if (i == 1) check("mw_lw_flushE", 32'(flushE), 32'd0);
            step();
        end
        exp_sc = exp_sc + 3;
        check("mw_idle", 32'(dut.u_fsm.state), 32'(IDLE));
        // Back-to-back access starts fresh from IDLE.
        dmem_ready = 1;
        #1;
        check("b2b_req", 32'(dmem_req), 32'd1);
        check("b2b_stall", 32'(stallF), 32'd0);
        step();
        clr();
        #1;
        check("idle_noreq", 32'(dmem_req), 32'd0);
        check("mw_count", stall_count, exp_sc);

        // Timeout on a store that never completes.
        memwriteM = 1;
        for (int i = 0; i <= 16; i++) begin
            #1;
            check("to_stallF", 32'(stallF), 32'(i < 16));
            check("to_err_pre", 32'(mem_error), 32'd0);
            if (i == 16) check("to_req", 32'(dmem_req), 32'd1);
            step();
        end
        exp_sc = exp_sc + 16;
        memwriteM = 0;
        #1;
        check("to_err", 32'(mem_error), 32'd1);
        check("to_idle", 32'(dut.u_fsm.state), 32'(IDLE));
        step();
        step();
        check("to_err_sticky", 32'(mem_error), 32'd1);
        check("to_count", stall_count, exp_sc);

        // Reset in the middle of a wait.
        memtoregM = 1;
        step();
        step();
        check("rw_in_wait", 32'(dut.u_fsm.state), 32'(WAIT));
        reset = 1'b1;
        #1;
        check("rw_req", 32'(dmem_req), 32'd0);
        check("rw_stallF", 32'(stallF), 32'd0);
        step();
        check("rw_idle", 32'(dut.u_fsm.state), 32'(IDLE));
        check("rw_count", stall_count, 32'd0);
        check("rw_err", 32'(mem_error), 32'd0);
        reset = 1'b0;
        clr();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
